riscv_control_fsm: RTL and testbench

Multi-cycle control FSM for the RISC-V core. It sequences instruction fetch, decode, execute (ALU), memory access and register writeback over one shared single-ported memory. It drives the IR/PC/register-file write enables, the ALU operand muxes, the memory request handshake and the PC source mux. The ALU remains purely combinational and decodes its own operation from opcode/funct3/funct7. This block only routes operands and decides when results are committed.

---
 rtl/riscv_pkg.sv | 45 ++++
 rtl/mem_timeout_ctr.sv | 33 +++
 rtl/riscv_control_fsm.sv | 152 +++++++++++++++
 tb/tb_riscv_control_fsm.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V control definitions: opcodes (also decoded by the ALU), FSM state
// codes and the select encodings driven onto the datapath muxes.
// No ports; imported by riscv_control_fsm and mem_timeout_ctr.
package riscv_pkg;

   typedef enum logic [6:0] {
      R_TYPE    = 7'b0110011,
      I_TYPE    = 7'b0010011,
      LOAD_TYPE = 7'b0000011,
      S_TYPE    = 7'b0100011,
      B_TYPE    = 7'b1100011,
      JAL       = 7'b1101111,
      JALR      = 7'b1100111,
      LUI       = 7'b0110111,
      AUIPC     = 7'b0010111,
      SYSTEM    = 7'b1110011
   } opcode_t;

   // Plain localparam state codes keep the encoding visible to older tools and dumps.
   typedef logic [2:0] ctrl_state_t;
   localparam ctrl_state_t ST_FETCH   = 3'd0;
   localparam ctrl_state_t ST_DECODE  = 3'd1;
   localparam ctrl_state_t ST_EXECUTE = 3'd2;
   localparam ctrl_state_t ST_MEM     = 3'd3;
   localparam ctrl_state_t ST_WB      = 3'd4;
   localparam ctrl_state_t ST_HALT    = 3'd5;
   localparam ctrl_state_t ST_TRAP    = 3'd6;

   localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
   localparam logic [1:0] PC_SRC_JALR   = 2'd2;

   localparam logic [1:0] SRC_A_RS1 = 2'd0;
   localparam logic [1:0] SRC_A_PC  = 2'd1;
   localparam logic [1:0] SRC_A_IMM = 2'd2;

   localparam logic [1:0] SRC_B_RS2  = 2'd0;
   localparam logic [1:0] SRC_B_IMM  = 2'd1;
   localparam logic [1:0] SRC_B_FOUR = 2'd2;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_LOAD = 2'd1;
   localparam logic [1:0] WB_PC4  = 2'd2;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts consecutive stalled memory-request cycles and flags expiry on the
// cycle the count reaches MEM_TIMEOUT-1 while still stalled.
// Ports: clk, rst_n, count (request pending, not ready), clear, expired.
module mem_timeout_ctr
   import riscv_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int TO_W        = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic count,
   input  logic clear,
   output logic expired
);

   localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT - 1);

   logic [TO_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (count)
         cnt <= cnt + 1'b1;
   end

   // Only a still-stalled request can expire; mem_ready in the same cycle wins.
   assign expired = count && (cnt == LIMIT);

endmodule

// File: rtl/riscv_control_fsm.sv
// Multi-cycle RISC-V control FSM: fetch/decode/execute/mem/writeback over one
// shared memory port, plus absorbing HALT/TRAP states.
// Ports: clk, rst_n, instr, mem_ready, branch_taken in; datapath enables,
// mux selects, memory handshake, instret pulse and sticky halted/trap out.
module riscv_control_fsm
   import riscv_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int TO_W        = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   input  logic        branch_taken,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_src,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic        instret,
   output logic        halted,
   output logic        trap
);

   ctrl_state_t state, state_nxt;
   logic [6:0]  op;
   logic        expired;
   logic        unused_instr_bits;

   assign op                = instr[6:0];
   assign unused_instr_bits = ^instr[31:7];

   // mem_req comes straight from state so the timeout counter never loops back
   // through the decode block; gating with rst_n keeps it low while in reset.
   assign mem_req = rst_n && ((state == ST_FETCH) || (state == ST_MEM));
   assign halted  = (state == ST_HALT);
   assign trap    = (state == ST_TRAP);

   mem_timeout_ctr #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TO_W        (TO_W)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .count   (mem_req && !mem_ready),
      .clear   (!mem_req || mem_ready),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_FETCH;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = PC_SRC_PLUS4;
      mem_we       = 1'b0;
      mem_addr_src = 1'b0;
      alu_src_a    = SRC_A_RS1;
      alu_src_b    = SRC_B_RS2;
      rf_we        = 1'b0;
      wb_sel       = WB_ALU;
      instret      = 1'b0;
      if (rst_n) begin
         case (state)
            ST_FETCH: begin
               if (mem_ready) begin
                  ir_we     = 1'b1;
                  state_nxt = ST_DECODE;
               end else if (expired) begin
                  state_nxt = ST_TRAP;
               end
            end
            ST_DECODE: begin
               case (op)
                  R_TYPE, I_TYPE, LOAD_TYPE, S_TYPE, B_TYPE,
                  JAL, JALR, LUI, AUIPC: state_nxt = ST_EXECUTE;
                  SYSTEM:                state_nxt = ST_HALT;
                  default:               state_nxt = ST_TRAP;
               endcase
            end
            ST_EXECUTE: begin
               case (op)
                  I_TYPE, LOAD_TYPE, S_TYPE: alu_src_b = SRC_B_IMM;
                  LUI:   alu_src_a = SRC_A_IMM;
                  AUIPC: begin
                     alu_src_a = SRC_A_PC;
                     alu_src_b = SRC_B_IMM;
                  end
                  JAL, JALR: begin
                     alu_src_a = SRC_A_PC;
                     alu_src_b = SRC_B_FOUR;
                  end
                  default: ;
               endcase
               if (op == B_TYPE) begin
                  pc_we     = 1'b1;
                  pc_src    = branch_taken ? PC_SRC_BRANCH : PC_SRC_PLUS4;
                  instret   = 1'b1;
                  state_nxt = ST_FETCH;
               end else if ((op == LOAD_TYPE) || (op == S_TYPE)) begin
                  state_nxt = ST_MEM;
               end else begin
                  state_nxt = ST_WB;
               end
            end
            ST_MEM: begin
               mem_addr_src = 1'b1;
               mem_we       = (op == S_TYPE);
               if (mem_ready) begin
                  if (op == S_TYPE) begin
                     pc_we     = 1'b1;
                     instret   = 1'b1;
                     state_nxt = ST_FETCH;
                  end else begin
                     state_nxt = ST_WB;
                  end
               end else if (expired) begin
                  state_nxt = ST_TRAP;
               end
            end
            ST_WB: begin
               rf_we     = 1'b1;
               pc_we     = 1'b1;
               instret   = 1'b1;
               state_nxt = ST_FETCH;
               if (op == LOAD_TYPE)
                  wb_sel = WB_LOAD;
               else if ((op == JAL) || (op == JALR))
                  wb_sel = WB_PC4;
               if (op == JAL)
                  pc_src = PC_SRC_BRANCH;
               else if (op == JALR)
                  pc_src = PC_SRC_JALR;
            end
            default: ;  // HALT and TRAP hold until reset
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_control_fsm.sv
// Randomized bench for riscv_control_fsm: each instruction is expanded into a
// per-cycle list of expected output vectors from its phase lengths (fetch wait,
// memory wait) and per-opcode select table, then replayed against the DUT.
module tb_riscv_control_fsm;

   localparam int MEM_TIMEOUT = 16;

   typedef struct packed {
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       mem_req;
      logic       mem_we;
      logic       mem_addr_src;
      logic [1:0] a;
      logic [1:0] b;
      logic       rf_we;
      logic [1:0] wb_sel;
      logic       instret;
      logic       halted;
      logic       trap;
   } vec_t;

   typedef struct {
      logic  rdy;
      logic  bt;
      vec_t  e;
      string tag;
   } step_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = '0;
   logic        mem_ready = 1'b0;
   logic        branch_taken = 1'b0;
   logic        ir_we, pc_we, mem_req, mem_we, mem_addr_src, rf_we, instret, halted, trap;
   logic [1:0]  pc_src, alu_src_a, alu_src_b, wb_sel;
   vec_t        dut_v;

   int    n_tests = 0;
   int    n_fail  = 0;
   step_t q[$];
   bit    terminal;

   always #5 clk = ~clk;

   riscv_control_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr        (instr),
      .mem_ready    (mem_ready),
      .branch_taken (branch_taken),
      .ir_we        (ir_we),
      .pc_we        (pc_we),
      .pc_src       (pc_src),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr_src (mem_addr_src),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .rf_we        (rf_we),
      .wb_sel       (wb_sel),
      .instret      (instret),
      .halted       (halted),
      .trap         (trap)
   );

   assign dut_v = '{ir_we, pc_we, pc_src, mem_req, mem_we, mem_addr_src,
                    alu_src_a, alu_src_b, rf_we, wb_sel, instret, halted, trap};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic push(input logic rdy, input logic bt, input vec_t e, input string tag);
      step_t s;
      s.rdy = rdy; s.bt = bt; s.e = e; s.tag = tag;
      q.push_back(s);
   endtask

   // Absorbing state: a few idle cycles with only the sticky flag set.
   task automatic push_tail(input bit is_trap, input string tag);
      vec_t e;
      for (int i = 0; i < 3; i++) begin
         e = '0;
         e.trap   = is_trap;
         e.halted = !is_trap;
         push(1'($urandom), 1'($urandom), e, tag);
      end
      terminal = 1'b1;
   endtask

   // Expected timeline of one instruction starting in FETCH.
   task automatic build(input logic [31:0] ins, input int fw, input int mw, input logic bt);
      vec_t       e;
      logic [6:0] op;
      bit         is_ld, is_st, done;
      op    = ins[6:0];
      is_ld = (op == 7'b0000011);
      is_st = (op == 7'b0100011);
      terminal = 1'b0;
      done = 1'b0;
      for (int i = 0; i < MEM_TIMEOUT && !done; i++) begin
         e = '0;
         e.mem_req = 1'b1;
         e.ir_we   = (i == fw);
         push(i == fw, 1'($urandom), e, "fetch");
         done = (i == fw);
      end
      if (!done) begin push_tail(1'b1, "fetch_timeout"); return; end
      push(1'($urandom), 1'($urandom), '0, "decode");
      if (op == 7'b1110011) begin push_tail(1'b0, "halt"); return; end
      if (!(op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                       7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111})) begin
         push_tail(1'b1, "illegal");
         return;
      end
      e = '0;
      case (op)
         7'b0010011, 7'b0000011, 7'b0100011: e.b = 2'd1;
         7'b0110111: e.a = 2'd2;
         7'b0010111: begin e.a = 2'd1; e.b = 2'd1; end
         7'b1101111, 7'b1100111: begin e.a = 2'd1; e.b = 2'd2; end
         default: ;
      endcase
      if (op == 7'b1100011) begin
         e.pc_we = 1'b1; e.pc_src = bt ? 2'd1 : 2'd0; e.instret = 1'b1;
         push(1'($urandom), bt, e, "exec_branch");
         return;
      end
      push(1'($urandom), 1'($urandom), e, "execute");
      if (is_ld || is_st) begin
         done = 1'b0;
         for (int i = 0; i < MEM_TIMEOUT && !done; i++) begin
            e = '0;
            e.mem_req = 1'b1; e.mem_addr_src = 1'b1; e.mem_we = is_st;
            if (i == mw && is_st) begin e.pc_we = 1'b1; e.instret = 1'b1; end
            push(i == mw, 1'($urandom), e, "mem");
            done = (i == mw);
         end
         if (!done) begin push_tail(1'b1, "mem_timeout"); return; end
         if (is_st) return;
      end
      e = '0;
      e.rf_we = 1'b1; e.pc_we = 1'b1; e.instret = 1'b1;
      if (is_ld) e.wb_sel = 2'd1;
      else if (op == 7'b1101111 || op == 7'b1100111) e.wb_sel = 2'd2;
      if (op == 7'b1101111) e.pc_src = 2'd1;
      else if (op == 7'b1100111) e.pc_src = 2'd2;
      push(1'($urandom), 1'($urandom), e, "wb");
   endtask

   // Replays the queue starting at a falling edge; ends on a falling edge.
   task automatic run_seq(input logic [31:0] ins);
      step_t s;
      instr = ins;
      while (q.size() > 0) begin
         s = q.pop_front();
         mem_ready    = s.rdy;
         branch_taken = s.bt;
         #1;
         chk(s.tag, 32'(dut_v), 32'(s.e));
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mem_ready = 1'b1;
      branch_taken = 1'b1;
      @(negedge clk);
      #1;
      chk("reset_outputs", 32'(dut_v), 32'd0);
      @(negedge clk);
      mem_ready = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic one(input logic [31:0] ins, input int fw, input int mw, input logic bt);
      build(ins, fw, mw, bt);
      run_seq(ins);
      if (terminal) do_reset();
   endtask

   initial begin
      logic [6:0]  ops [12];
      logic [31:0] ins;
      int          fw, mw;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
              7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011, 7'b1111111, 7'b0001011};

      do_reset();
      one(32'h002081B3, 0, 0, 1'b0);               // ADD, zero-wait
      one(32'h0000A103, 0, 2, 1'b0);               // LW, two MEM stalls
      one(32'h00208463, 0, 0, 1'b1);               // BEQ taken
      one(32'h00208463, 0, 0, 1'b0);               // BEQ not taken
      one(32'h000080E7, 1, 0, 1'b0);               // JALR
      one(32'h0020A023, 0, 15, 1'b0);              // SW, ready on expiry cycle wins
      one(32'h002081B3, 15, 0, 1'b0);              // fetch ready on expiry cycle wins
      one(32'h002081B3, 16, 0, 1'b0);              // fetch timeout -> trap
      one(32'h0000A103, 0, 16, 1'b0);              // MEM timeout -> trap
      one(32'h0000007F, 0, 0, 1'b0);               // illegal opcode
      one(32'h00000073, 0, 0, 1'b0);               // ECALL -> halt

      // Store stalled in MEM, reset asserted mid-cycle.
      build(32'h0020A023, 0, 5, 1'b0);
      while (q.size() > 5) void'(q.pop_back());
      run_seq(32'h0020A023);
      mem_ready = 1'b0;
      #1;
      chk("store_stalled_req", 32'({mem_req, mem_we, mem_addr_src}), 32'b111);
      #1 rst_n = 1'b0;
      #1;
      chk("async_reset_drop", 32'(dut_v), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      one(32'h002081B3, 0, 0, 1'b0);               // clean restart from FETCH

      for (int n = 0; n < 120; n++) begin
         ins = {$urandom_range(0, 32'h1FFFFFF), 7'b0};
         ins[6:0] = ops[$urandom_range(0, 11)];
         fw = ($urandom_range(0, 15) == 0) ? $urandom_range(14, 16) : $urandom_range(0, 2);
         mw = ($urandom_range(0, 15) == 0) ? $urandom_range(14, 16) : $urandom_range(0, 2);
         one(ins, fw, mw, 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
